// File: rtl/axi_lite_mem_slave_if.sv
// AXI4-Lite channel bundle for one master port of the bus interconnect.
// The master modport drives requests; the slave modport drives readies and responses.
interface axi_lite_mem_slave_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned RESP_WIDTH = 3
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8 + 1;

  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [RESP_WIDTH-1:0] bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [RESP_WIDTH-1:0] rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_lite_mem_slave.sv
// AXI4-Lite flop memory slave: DEPTH 32-bit words, byte-strobed writes, SLVERR outside
// the window. Independent write and read engines, one outstanding transaction each.
module axi_lite_mem_slave #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned RESP_WIDTH = 3,
  parameter int unsigned BASE_ADDR  = 0,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                s0_axi_aclk,
  input  logic                s0_axi_aresetn,
  axi_lite_mem_slave_if.slave s0_axi
);
  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned WINDOW = DEPTH * 4;
  localparam logic [ADDR_WIDTH-1:0] BASE        = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [RESP_WIDTH-1:0] RESP_OKAY   = RESP_WIDTH'(0);
  localparam logic [RESP_WIDTH-1:0] RESP_SLVERR = RESP_WIDTH'(2);

  typedef enum logic [1:0] {W_IDLE, W_GOT_A, W_GOT_D, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA} r_state_t;

  // Extra top bit of the subtraction is the borrow, i.e. addr below BASE.
  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH:0] off_ext;
    off_ext = {1'b0, addr} - {1'b0, BASE};
    return !off_ext[ADDR_WIDTH] && (32'(off_ext[ADDR_WIDTH-1:0]) < WINDOW);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] off;
    off = addr - BASE;
    return IDX_W'(off >> 2);
  endfunction

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  w_state_t              w_state;
  r_state_t              r_state;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]     wstrb_q;

  logic                  aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic                  commit_en;
  logic [ADDR_WIDTH-1:0] commit_addr;
  logic [DATA_WIDTH-1:0] commit_data;
  logic [STRB_W-1:0]     commit_strb;
  logic                  unused_strb_msb;

  assign aw_hs = s0_axi.awvalid && s0_axi.awready;
  assign w_hs  = s0_axi.wvalid  && s0_axi.wready;
  assign b_hs  = s0_axi.bvalid  && s0_axi.bready;
  assign ar_hs = s0_axi.arvalid && s0_axi.arready;
  assign r_hs  = s0_axi.rvalid  && s0_axi.rready;
  assign unused_strb_msb = s0_axi.wstrb[STRB_W];

  // The edge that completes the AW/W pair commits, merging latched and live halves.
  always_comb begin
    commit_en   = 1'b0;
    commit_addr = (w_state == W_GOT_A) ? awaddr_q : s0_axi.awaddr;
    commit_data = (w_state == W_GOT_D) ? wdata_q  : s0_axi.wdata;
    commit_strb = (w_state == W_GOT_D) ? wstrb_q  : s0_axi.wstrb[STRB_W-1:0];
    case (w_state)
      W_IDLE:  commit_en = aw_hs && w_hs;
      W_GOT_A: commit_en = w_hs;
      W_GOT_D: commit_en = aw_hs;
      default: commit_en = 1'b0;
    endcase
  end

  always_ff @(posedge s0_axi_aclk or negedge s0_axi_aresetn) begin
    if (!s0_axi_aresetn) begin
      w_state        <= W_IDLE;
      s0_axi.awready <= 1'b0;
      s0_axi.wready  <= 1'b0;
      s0_axi.bvalid  <= 1'b0;
      s0_axi.bresp   <= RESP_OKAY;
      awaddr_q       <= '0;
      wdata_q        <= '0;
      wstrb_q        <= '0;
    end else if (commit_en) begin
      w_state        <= W_RESP;
      s0_axi.awready <= 1'b0;
      s0_axi.wready  <= 1'b0;
      s0_axi.bvalid  <= 1'b1;
      s0_axi.bresp   <= in_range(commit_addr) ? RESP_OKAY : RESP_SLVERR;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_hs) begin
            w_state        <= W_GOT_A;
            awaddr_q       <= s0_axi.awaddr;
            s0_axi.awready <= 1'b0;
            s0_axi.wready  <= 1'b1;
          end else if (w_hs) begin
            w_state        <= W_GOT_D;
            wdata_q        <= s0_axi.wdata;
            wstrb_q        <= s0_axi.wstrb[STRB_W-1:0];
            s0_axi.awready <= 1'b1;
            s0_axi.wready  <= 1'b0;
          end else begin
            s0_axi.awready <= 1'b1;
            s0_axi.wready  <= 1'b1;
          end
        end
        W_RESP: begin
          if (b_hs) begin
            w_state        <= W_IDLE;
            s0_axi.bvalid  <= 1'b0;
            s0_axi.awready <= 1'b1;
            s0_axi.wready  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge s0_axi_aclk or negedge s0_axi_aresetn) begin
    if (!s0_axi_aresetn) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (commit_en && in_range(commit_addr)) begin
      for (int b = 0; b < int'(STRB_W); b++) begin
        if (commit_strb[b]) mem[word_idx(commit_addr)][8*b +: 8] <= commit_data[8*b +: 8];
      end
    end
  end

  // Nonblocking memory update makes a same-edge read see the pre-write word.
  always_ff @(posedge s0_axi_aclk or negedge s0_axi_aresetn) begin
    if (!s0_axi_aresetn) begin
      r_state        <= R_IDLE;
      s0_axi.arready <= 1'b0;
      s0_axi.rvalid  <= 1'b0;
      s0_axi.rdata   <= '0;
      s0_axi.rresp   <= RESP_OKAY;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            r_state        <= R_DATA;
            s0_axi.arready <= 1'b0;
            s0_axi.rvalid  <= 1'b1;
            if (in_range(s0_axi.araddr)) begin
              s0_axi.rdata <= mem[word_idx(s0_axi.araddr)];
              s0_axi.rresp <= RESP_OKAY;
            end else begin
              s0_axi.rdata <= '0;
              s0_axi.rresp <= RESP_SLVERR;
            end
          end else begin
            s0_axi.arready <= 1'b1;
          end
        end
        R_DATA: begin
          if (r_hs) begin
            r_state        <= R_IDLE;
            s0_axi.rvalid  <= 1'b0;
            s0_axi.arready <= 1'b1;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_lite_mem_slave.sv
// Self-checking bench for axi_lite_mem_slave: reset, vector table, split/backpressure,
// collision, randomized traffic against a word-array model, and reset mid-read.
module tb_axi_lite_mem_slave;
  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 8;
  localparam int unsigned RW    = 3;
  localparam int unsigned BASE  = 0;
  localparam int unsigned DEPTH = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi_lite_mem_slave_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESP_WIDTH(RW)) bus ();

  axi_lite_mem_slave #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESP_WIDTH(RW), .BASE_ADDR(BASE), .DEPTH(DEPTH)
  ) dut (
    .s0_axi_aclk   (clk),
    .s0_axi_aresetn(rst_n),
    .s0_axi        (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] model [DEPTH];

  typedef struct {
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [4:0]  strb;
    logic [2:0]  exp_resp;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: handshake timed out", name);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: window rule and byte lanes straight from the address map.
  function automatic bit m_in_range(input int unsigned a);
    int off;
    off = int'(a) - int'(BASE);
    return (off >= 0) && (off < int'(DEPTH * 4));
  endfunction

  function automatic logic [2:0] m_write(input int unsigned a, input logic [31:0] d,
                                         input logic [4:0] s);
    int idx;
    if (!m_in_range(a)) return 3'd2;
    idx = (int'(a) - int'(BASE)) / 4;
    for (int b = 0; b < 4; b++) if (s[b]) model[idx][8*b +: 8] = d[8*b +: 8];
    return 3'd0;
  endfunction

  task automatic m_read(input int unsigned a, output logic [31:0] d, output logic [2:0] r);
    if (m_in_range(a)) begin
      d = model[(int'(a) - int'(BASE)) / 4];
      r = 3'd0;
    end else begin
      d = 32'h0;
      r = 3'd2;
    end
  endtask

  task automatic m_clear();
    for (int i = 0; i < int'(DEPTH); i++) model[i] = 32'h0;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [4:0] s,
                          input int aw_dly, input int w_dly, input int b_dly,
                          output logic [2:0] resp);
    bit aw_done = 0, w_done = 0, hs_aw, hs_w;
    int cyc = 0;
    bus.awaddr = a;
    bus.wdata  = d;
    bus.wstrb  = s;
    while (!(aw_done && w_done) && cyc < 50) begin
      bus.awvalid = !aw_done && (cyc >= aw_dly);
      bus.wvalid  = !w_done && (cyc >= w_dly);
      hs_aw = bus.awvalid && bus.awready;
      hs_w  = bus.wvalid && bus.wready;
      step();
      if (hs_aw) aw_done = 1;
      if (hs_w)  w_done  = 1;
      cyc++;
    end
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    if (!(aw_done && w_done) || !bus.bvalid) begin
      timeout_fail("write_handshake");
      resp = 'x;
      return;
    end
    for (int k = 0; k < b_dly; k++) step();
    resp = bus.bresp;
    bus.bready = 1'b1;
    step();
    bus.bready = 1'b0;
  endtask

  task automatic do_read(input logic [7:0] a, input int ar_dly, input int r_dly,
                         output logic [31:0] data, output logic [2:0] resp);
    bit done = 0, hs;
    int cyc = 0;
    bus.araddr = a;
    while (!done && cyc < 50) begin
      bus.arvalid = (cyc >= ar_dly);
      hs = bus.arvalid && bus.arready;
      step();
      done = hs;
      cyc++;
    end
    bus.arvalid = 1'b0;
    if (!done || !bus.rvalid) begin
      timeout_fail("read_handshake");
      data = 'x;
      resp = 'x;
      return;
    end
    for (int k = 0; k < r_dly; k++) step();
    data = bus.rdata;
    resp = bus.rresp;
    bus.rready = 1'b1;
    step();
    bus.rready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, exp_d;
    logic [2:0]  rr, exp_r;

    bus.awaddr = '0; bus.awvalid = 0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 0;
    bus.bready = 0;  bus.araddr = '0; bus.arvalid = 0; bus.rready = 0;
    m_clear();

    vecs[0]  = '{1, 8'h00, 32'h0000_0038, 5'h0F, 3'd0, 32'h0};
    vecs[1]  = '{0, 8'h00, 32'h0,         5'h00, 3'd0, 32'h0000_0038};
    vecs[2]  = '{1, 8'h10, 32'hDEAD_BEEF, 5'h0F, 3'd2, 32'h0};
    vecs[3]  = '{0, 8'h10, 32'h0,         5'h00, 3'd2, 32'h0};
    vecs[4]  = '{1, 8'h0C, 32'h1234_5678, 5'h08, 3'd0, 32'h0};
    vecs[5]  = '{0, 8'h0C, 32'h0,         5'h00, 3'd0, 32'h1200_0000};
    vecs[6]  = '{1, 8'h0D, 32'hAABB_CCDD, 5'h01, 3'd0, 32'h0};
    vecs[7]  = '{0, 8'h0F, 32'h0,         5'h00, 3'd0, 32'h1200_00DD};
    vecs[8]  = '{1, 8'h00, 32'hFFFF_FFFF, 5'h10, 3'd0, 32'h0};
    vecs[9]  = '{0, 8'h00, 32'h0,         5'h00, 3'd0, 32'h0000_0038};
    vecs[10] = '{0, 8'hFF, 32'h0,         5'h00, 3'd2, 32'h0};
    vecs[11] = '{0, 8'h08, 32'h0,         5'h00, 3'd0, 32'h0};

    // Reset: everything low while held, readies rise one edge after release.
    step();
    check("rst_awready", 32'(bus.awready), 0);
    check("rst_wready",  32'(bus.wready),  0);
    check("rst_arready", 32'(bus.arready), 0);
    check("rst_bvalid",  32'(bus.bvalid),  0);
    check("rst_rvalid",  32'(bus.rvalid),  0);
    check("rst_bresp",   32'(bus.bresp),   0);
    check("rst_rresp",   32'(bus.rresp),   0);
    check("rst_rdata",   bus.rdata,        0);
    step();
    rst_n = 1'b1;
    check("rel_awready_before_edge", 32'(bus.awready), 0);
    step();
    check("rel_awready", 32'(bus.awready), 1);
    check("rel_wready",  32'(bus.wready),  1);
    check("rel_arready", 32'(bus.arready), 1);
    do_read(8'h00, 0, 0, rd, rr);
    check("rst_read0_data", rd, 0);
    check("rst_read0_resp", 32'(rr), 0);

    // Vector table.
    foreach (vecs[i]) begin
      if (vecs[i].wr) begin
        do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, 0, 0, 0, rr);
        exp_r = m_write(int'(vecs[i].addr), vecs[i].data, vecs[i].strb);
        check($sformatf("vec%0d_bresp", i), 32'(rr), 32'(vecs[i].exp_resp));
      end else begin
        do_read(vecs[i].addr, 0, 0, rd, rr);
        check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
        check($sformatf("vec%0d_rresp", i), 32'(rr), 32'(vecs[i].exp_resp));
      end
    end

    // Split: W first, AW three edges later, then B backpressure.
    bus.wdata = 32'hAABB_CCDD; bus.wstrb = 5'b00101; bus.wvalid = 1'b1;
    step();
    bus.wvalid = 1'b0;
    check("split_wready_low",   32'(bus.wready),  0);
    check("split_awready_high", 32'(bus.awready), 1);
    step();
    step();
    bus.awaddr = 8'h04; bus.awvalid = 1'b1;
    step();
    bus.awvalid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("split_bvalid_held", 32'(bus.bvalid),  1);
      check("split_bresp_held",  32'(bus.bresp),   0);
      check("split_awready_low", 32'(bus.awready), 0);
      check("split_wready_low2", 32'(bus.wready),  0);
      step();
    end
    bus.bready = 1'b1;
    step();
    bus.bready = 1'b0;
    check("split_bvalid_done",  32'(bus.bvalid),  0);
    check("split_awready_back", 32'(bus.awready), 1);
    check("split_wready_back",  32'(bus.wready),  1);
    exp_r = m_write(4, 32'hAABB_CCDD, 5'b00101);
    do_read(8'h04, 0, 0, rd, rr);
    check("split_readback", rd, 32'h00BB_00DD);

    // Same-edge read and write of one word: read sees the old value.
    do_write(8'h08, 32'h11, 5'h0F, 0, 0, 0, rr);
    check("coll_pre_bresp", 32'(rr), 0);
    bus.awaddr = 8'h08; bus.wdata = 32'h22; bus.wstrb = 5'h0F; bus.araddr = 8'h08;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.arvalid = 1'b1;
    step();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    check("coll_rvalid", 32'(bus.rvalid), 1);
    check("coll_rdata",  bus.rdata, 32'h11);
    check("coll_bvalid", 32'(bus.bvalid), 1);
    check("coll_bresp",  32'(bus.bresp), 0);
    bus.rready = 1'b1; bus.bready = 1'b1;
    step();
    bus.rready = 1'b0; bus.bready = 1'b0;
    exp_r = m_write(8, 32'h22, 5'h0F);
    do_read(8'h08, 0, 0, rd, rr);
    check("coll_after", rd, 32'h22);

    // Randomized traffic against the model.
    for (int i = 0; i < 60; i++) begin
      logic [7:0]  a;
      logic [31:0] d;
      logic [4:0]  s;
      a = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(16, 255)) : 8'($urandom_range(0, 15));
      d = $urandom;
      s = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 1) == 1) begin
        do_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), rr);
        exp_r = m_write(int'(a), d, s);
        check($sformatf("rand%0d_bresp", i), 32'(rr), 32'(exp_r));
      end else begin
        do_read(a, $urandom_range(0, 3), $urandom_range(0, 3), rd, rr);
        m_read(int'(a), exp_d, exp_r);
        check($sformatf("rand%0d_rdata", i), rd, exp_d);
        check($sformatf("rand%0d_rresp", i), 32'(rr), 32'(exp_r));
      end
    end

    // Reset while a read response is pending.
    bus.araddr = 8'h00; bus.arvalid = 1'b1;
    step();
    bus.arvalid = 1'b0;
    check("mid_rvalid_pre", 32'(bus.rvalid), 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rvalid_drop", 32'(bus.rvalid),  0);
    check("mid_arready",     32'(bus.arready), 0);
    check("mid_rdata",       bus.rdata,        0);
    step();
    step();
    rst_n = 1'b1;
    m_clear();
    step();
    check("mid_arready_back", 32'(bus.arready), 1);
    do_read(8'h08, 0, 0, rd, rr);
    check("mid_fresh_rdata", rd, 0);
    check("mid_fresh_rresp", 32'(rr), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/axi_lite_mem_slave.md
# axi_lite_mem_slave

AXI4-Lite slave memory that terminates one master port (m1 or m2) of the `bus` interconnect, one instance per master port. Holds DEPTH 32-bit words in flops with byte-strobe writes. Accepts one write and one read at a time, with independent write and read engines. Out-of-window accesses return SLVERR.

## Interface
- DATA_WIDTH, 32, data bus width in bits (only 32 is supported)
- ADDR_WIDTH, 8, byte address width
- RESP_WIDTH, 3, response field width
- BASE_ADDR, 0, byte address of word 0
- DEPTH, 4, number of words (window is DEPTH*4 bytes)

Ports:
- s0_axi_aclk  in  1  sole clock, rising edge
- s0_axi_aresetn  in  1  reset, asynchronous, active-low
- s0_axi_awaddr  in  ADDR_WIDTH  write byte address
- s0_axi_awvalid / s0_axi_awready  in / out  1  write-address handshake
- s0_axi_wdata  in  DATA_WIDTH  write data
- s0_axi_wstrb  in  DATA_WIDTH/8+1  byte enables; bit i enables byte i; top bit ignored
- s0_axi_wvalid / s0_axi_wready  in / out  1  write-data handshake
- s0_axi_bresp  out  RESP_WIDTH  write response: 0 = OKAY, 2 = SLVERR
- s0_axi_bvalid / s0_axi_bready  out / in  1  write-response handshake
- s0_axi_araddr  in  ADDR_WIDTH  read byte address
- s0_axi_arvalid / s0_axi_arready  in / out  1  read-address handshake
- s0_axi_rdata  out  DATA_WIDTH  read data
- s0_axi_rresp  out  RESP_WIDTH  read response: 0 = OKAY, 2 = SLVERR
- s0_axi_rvalid / s0_axi_rready  out / in  1  read-data handshake

## Operation
- **Address decode.** off = addr - BASE_ADDR, computed at ADDR_WIDTH width.
  - In range iff addr >= BASE_ADDR and off < DEPTH*4.
  - Word index = off >> 2; addr[1:0] is ignored.
- **Write FSM states:** W_IDLE, W_GOT_A, W_GOT_D, W_RESP.
  - W_IDLE: awready = 1, wready = 1.
    - AW only -> W_GOT_A, latch awaddr.
    - W only -> W_GOT_D, latch wdata and wstrb.
    - AW and W in the same cycle -> W_RESP.
  - W_GOT_A: awready = 0, wready = 1. W handshake -> W_RESP.
  - W_GOT_D: awready = 1, wready = 0. AW handshake -> W_RESP.
  - On entry to W_RESP, a write to an in-range address updates only strobed bytes. An out-of-range write leaves memory unchanged.
  - W_RESP: awready = 0, wready = 0, bvalid = 1. bresp = 0 (in range) or 2 (out of range).
  - W_RESP with bready = 1 -> W_IDLE.
- **Read FSM states:** R_IDLE, R_DATA.
  - R_IDLE: arready = 1. AR handshake -> R_DATA; rdata and rresp are registered on the same edge.
  - Out-of-range read: rdata = 0, rresp = 2.
  - R_DATA: arready = 0, rvalid = 1. rdata and rresp are held stable until the rready handshake, then -> R_IDLE.
- **Read/write collision.** On the same edge and same word, the read captures the pre-write contents (read-before-write).
- The write and read engines run fully concurrently. Neither engine stalls the other.

## Timing
- While reset is asserted, all outputs are 0: readies, bvalid, rvalid, bresp, rresp, rdata. Memory words are 0 and both FSMs are in IDLE.
- Readies are registered. They rise at the first rising edge after reset deasserts and are never asserted during reset.
- Write latency: the last of AW/W accepted at edge N -> bvalid = 1 after edge N, memory updated at edge N.
  - The next write can be accepted at the edge after the B handshake, because readies reassert when W_IDLE is re-entered.
  - Throughput is one write per 2 cycles minimum.
- Read latency: AR accepted at edge N -> rvalid = 1 after edge N. Throughput is one read per 2 cycles minimum.
- bvalid and rvalid, once asserted, stay high with stable payload until the ready handshake, independent of other inputs.
- Reset asserted mid-transaction aborts immediately: outputs go to reset values and no partial write occurs.
  - A write committed before reset asserts is still cleared by reset.
- Valid dropping before its handshake (protocol violation) is ignored. No state change occurs without a handshake.

## Test plan
- **Reset.** Hold aresetn = 0 for 2 cycles, then release. All outputs are 0 during reset; awready, wready and arready go to 1 one edge after release; a read of address 0 returns 0 with OKAY.
- **Aligned write and readback.** AW and W same cycle, awaddr 0, wdata 56, wstrb 15 -> bvalid next cycle with bresp 0. A read of address 0 then returns 56 with rresp 0.
- **Split AW/W with backpressure.** W first (wdata 0xAABBCCDD to address 4, wstrb 0b0101), AW 3 cycles later, bready held 0 for 4 cycles.
  - bvalid and bresp are stable throughout the backpressure; awready and wready stay 0 until the B handshake.
  - Readback of address 4 shows only bytes 0 and 2 updated (0x00BB00DD from a zero start).
- **Out of range.** Write awaddr 16 and read araddr 16 with DEPTH 4 and BASE_ADDR 0 -> bresp 2, rresp 2, rdata 0. Memory is unchanged.
- **Concurrent and collision.** Read and write to address 8 accepted at the same edge (old value 0x11, new value 0x22) -> rdata 0x11 returned; a subsequent read returns 0x22.
- **Reset mid-read.** Reset asserted while rvalid = 1 with rready = 0 -> rvalid drops immediately; after release, the engine accepts a fresh read.
